// File: rtl/input_event_capture_pkg.sv
// ============================================================================
// input_event_capture_pkg : shared types for the input event capture block
// Rev 1.0
// ============================================================================
`default_nettype none

package input_event_capture_pkg;

    localparam int N_INPUTS     = 8;
    localparam int TS_W_DEFAULT = 32;

    typedef logic [N_INPUTS-1:0] input_signals_t;

    typedef struct packed {
        logic [TS_W_DEFAULT-1:0] timestamp;
        input_signals_t          rise;
        input_signals_t          fall;
    } event_record_t;

endpackage

`default_nettype wire

// File: rtl/input_event_capture_event_fifo.sv
// ============================================================================
// input_event_capture_event_fifo : single-clock FIFO for event records
// Rev 1.0
// ============================================================================
`default_nettype none

module input_event_capture_event_fifo #(
    parameter int  DEPTH     = 16,
    parameter type PAYLOAD_T = logic [7:0]
) (
    input  logic     clock,
    input  logic     reset_n,
    input  logic     i_push,
    input  PAYLOAD_T i_data,
    input  logic     i_pop,
    output logic     o_full,
    output logic     o_empty,
    output PAYLOAD_T o_head
);

    localparam int AW = $clog2(DEPTH);

    PAYLOAD_T       r_mem [DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic           w_wr_en;
    logic           w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
    assign w_rd_en = i_pop && !o_empty;
    assign w_wr_en = i_push && (!o_full || w_rd_en);

    // Zero the head while empty so the outputs read 0 out of reset.
    assign o_head  = o_empty ? PAYLOAD_T'('0) : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/input_event_capture.sv
// ============================================================================
// input_event_capture : synchronise inputs, timestamp edges, queue events
// Rev 1.0
// ============================================================================
`default_nettype none

module input_event_capture
    import input_event_capture_pkg::*;
#(
    parameter int TS_W       = TS_W_DEFAULT,
    parameter int FIFO_DEPTH = 16,
    parameter int OVF_W      = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [N_INPUTS-1:0] data,
    input  logic                enable,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [TS_W-1:0]     out_timestamp,
    output logic [N_INPUTS-1:0] out_rise,
    output logic [N_INPUTS-1:0] out_fall,
    output logic                overflow,
    output logic [OVF_W-1:0]    overflow_count,
    input  logic                clear_overflow
);

    // Local record follows TS_W; matches event_record_t at the default width.
    typedef struct packed {
        logic [TS_W-1:0] timestamp;
        input_signals_t  rise;
        input_signals_t  fall;
    } rec_t;

    localparam logic [OVF_W-1:0] c_ovf_max = '1;

    input_signals_t     r_sync_q1;
    input_signals_t     r_sync_q2;
    input_signals_t     r_prev;
    logic [TS_W-1:0]    r_ts;
    logic               r_overflow;
    logic [OVF_W-1:0]   r_ovf_count;

    input_signals_t     w_rise;
    input_signals_t     w_fall;
    logic               w_event;
    logic               w_pop;
    logic               w_drop;
    logic               w_full;
    logic               w_empty;
    rec_t               w_rec;
    rec_t               w_head;

    assign w_rise  = r_sync_q2 & ~r_prev;
    assign w_fall  = ~r_sync_q2 & r_prev;
    assign w_event = enable && ((w_rise | w_fall) != '0);
    assign w_pop   = out_valid && out_ready;
    assign w_drop  = w_event && w_full && !w_pop;

    always_comb begin
        w_rec           = '0;
        w_rec.timestamp = r_ts;
        w_rec.rise      = w_rise;
        w_rec.fall      = w_fall;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_q1 <= '0;
            r_sync_q2 <= '0;
            r_prev    <= '0;
            r_ts      <= '0;
        end else begin
            r_sync_q1 <= data;
            r_sync_q2 <= r_sync_q1;
            r_prev    <= r_sync_q2;
            r_ts      <= r_ts + 1'b1;
        end
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow  <= 1'b0;
            r_ovf_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clear_overflow)
                r_ovf_count <= {{(OVF_W-1){1'b0}}, 1'b1};
            else if (r_ovf_count != c_ovf_max)
                r_ovf_count <= r_ovf_count + 1'b1;
        end else if (clear_overflow) begin
            r_overflow  <= 1'b0;
            r_ovf_count <= '0;
        end
    end

    input_event_capture_event_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .PAYLOAD_T (rec_t)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_event),
        .i_data  (w_rec),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign out_valid      = !w_empty;
    assign out_timestamp  = w_head.timestamp;
    assign out_rise       = w_head.rise;
    assign out_fall       = w_head.fall;
    assign overflow       = r_overflow;
    assign overflow_count = r_ovf_count;

endmodule

`default_nettype wire

// File: tb/tb_input_event_capture.sv
// ============================================================================
// tb_input_event_capture : randomised and directed bench with queue model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_input_event_capture;
    import input_event_capture_pkg::*;

    localparam int DEPTH   = 16;
    localparam int OVF_MAX = 65535;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        enable = 1'b0;
    logic        out_ready = 1'b0;
    logic        clear_overflow = 1'b0;
    logic        out_valid;
    logic [31:0] out_timestamp;
    logic [7:0]  out_rise;
    logic [7:0]  out_fall;
    logic        overflow;
    logic [15:0] overflow_count;

    input_event_capture dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data           (data),
        .enable         (enable),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_timestamp  (out_timestamp),
        .out_rise       (out_rise),
        .out_fall       (out_fall),
        .overflow       (overflow),
        .overflow_count (overflow_count),
        .clear_overflow (clear_overflow)
    );

    always #10 clock = ~clock;

    // Reference model: queue of expected records, data history, cycle number.
    event_record_t exp_q[$];
    logic [7:0]    h1, h2, h3;
    int unsigned   cyc_n;
    bit            m_ovf;
    int            m_cnt;
    int            n_vec = 0;
    int            n_err = 0;
    logic [7:0]    cur_d = 8'h00;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
        if (exp_q.size() != 0 && out_valid) begin
            check_eq("timestamp", {32'd0, out_timestamp}, {32'd0, exp_q[0].timestamp});
            check_eq("rise", {56'd0, out_rise}, {56'd0, exp_q[0].rise});
            check_eq("fall", {56'd0, out_fall}, {56'd0, exp_q[0].fall});
        end
        check_eq("overflow", {63'd0, overflow}, {63'd0, m_ovf});
        check_eq("ovf_count", {48'd0, overflow_count}, 64'(m_cnt));
    endtask

    // Drive one cycle's inputs, advance the model across the next edge, check.
    task automatic step(input logic [7:0] d, input logic en, input logic rdy, input logic clr);
        logic [7:0]    r, f;
        logic          ev, pop, full, drop;
        event_record_t rec;
        data = d; enable = en; out_ready = rdy; clear_overflow = clr;
        cur_d = d;
        r    = h2 & ~h3;
        f    = ~h2 & h3;
        ev   = en && ((r | f) != 8'h00);
        pop  = rdy && (exp_q.size() != 0);
        full = (exp_q.size() == DEPTH);
        drop = ev && full && !pop;
        if (pop) void'(exp_q.pop_front());
        if (ev && !drop) begin
            rec.timestamp = cyc_n;
            rec.rise      = r;
            rec.fall      = f;
            exp_q.push_back(rec);
        end
        if (drop) begin
            m_ovf = 1'b1;
            if (clr) m_cnt = 1;
            else if (m_cnt < OVF_MAX) m_cnt = m_cnt + 1;
        end else if (clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        h3 = h2; h2 = h1; h1 = d;
        cyc_n++;
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    task automatic model_reset();
        exp_q.delete();
        h1 = 8'h00; h2 = 8'h00; h3 = 8'h00;
        cyc_n = 0; m_ovf = 1'b0; m_cnt = 0;
    endtask

    // Assert reset mid-cycle, confirm it acts without a clock edge, release after an edge.
    task automatic do_reset();
        #4;
        reset_n = 1'b0;
        #1;
        check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_overflow", {63'd0, overflow}, 64'd0);
        check_eq("rst_count", {48'd0, overflow_count}, 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        check_eq("init_valid", {63'd0, out_valid}, 64'd0);
        check_eq("init_ts", {32'd0, out_timestamp}, 64'd0);
        check_eq("init_count", {48'd0, overflow_count}, 64'd0);
        reset_n = 1'b1;

        // Data generator: 0..7 then back to 0, one step every 5 cycles.
        for (int v = 0; v <= 8; v++)
            for (int k = 0; k < 5; k++) step(8'(v % 8), 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(8'h00, 1'b1, 1'b1, 1'b0);

        // Single change between edges 10 and 11.
        do_reset();
        for (int k = 0; k < 10; k++) step(8'h00, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(8'h01, 1'b1, 1'b0, 1'b0);
        check_eq("lat_valid", {63'd0, out_valid}, 64'd1);
        check_eq("lat_ts", {32'd0, out_timestamp}, 64'd12);
        check_eq("lat_rise", {56'd0, out_rise}, 64'h01);
        for (int k = 0; k < 3; k++) step(8'h01, 1'b1, 1'b1, 1'b0);

        // 18 changes with the consumer stalled.
        for (int k = 0; k < 18; k++) step(cur_d ^ 8'h10, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(cur_d, 1'b1, 1'b0, 1'b0);
        check_eq("ovf_flag", {63'd0, overflow}, 64'd1);
        check_eq("ovf_two", {48'd0, overflow_count}, 64'd2);

        // Full FIFO: event detected in the same cycle as a pop.
        step(cur_d ^ 8'h20, 1'b1, 1'b0, 1'b0);
        step(cur_d, 1'b1, 1'b0, 1'b0);
        step(cur_d, 1'b1, 1'b1, 1'b0);
        step(cur_d, 1'b1, 1'b0, 1'b0);
        check_eq("full_swap_count", {48'd0, overflow_count}, 64'd2);
        for (int k = 0; k < 20; k++) step(cur_d, 1'b1, 1'b1, 1'b0);
        step(cur_d, 1'b1, 1'b1, 1'b1);
        check_eq("clear_flag", {63'd0, overflow}, 64'd0);

        // Enable gating.
        for (int k = 0; k < 4; k++) step(8'h00, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) step(8'h0F, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(8'h0F, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(8'h00, 1'b1, 1'b0, 1'b0);
        check_eq("en_fall", {56'd0, out_fall}, 64'h0F);
        for (int k = 0; k < 2; k++) step(8'h00, 1'b1, 1'b1, 1'b0);

        // Reset with five events queued, then priming with data=03h.
        for (int k = 0; k < 5; k++) step(cur_d ^ 8'h40, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(cur_d, 1'b1, 1'b0, 1'b0);
        check_eq("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        do_reset();
        for (int k = 0; k < 4; k++) step(8'h03, 1'b1, 1'b0, 1'b0);
        check_eq("prime_rise", {56'd0, out_rise}, 64'h03);
        check_eq("prime_fall", {56'd0, out_fall}, 64'h00);
        for (int k = 0; k < 3; k++) step(8'h03, 1'b1, 1'b1, 1'b0);

        // Randomised traffic, including stalls long enough to overflow.
        for (int k = 0; k < 600; k++) begin
            logic [7:0] d;
            d = cur_d;
            if ($urandom_range(2) == 0) d = d ^ 8'($urandom);
            step(d, $urandom_range(9) != 0, (k % 150) < 100 ? $urandom_range(1) == 0 : 1'b0,
                 $urandom_range(29) == 0);
        end
        for (int k = 0; k < 24; k++) step(cur_d, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
